// File: rtl/muldiv_seq_if.sv
// Decode-side handshake and HI/LO read bus for the iterative multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 multiply/divide sequencer with architectural HI/LO: 32 ITER steps on magnitudes,
// then one FIX cycle that applies the sign correction and commits the result.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v[XLEN-1] ? -v : v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q;
  logic [XLEN-1:0]    hi_q, lo_q;

  // Datapath state: {upper, multiplier} for multiply, {remainder, dividend/quotient} for divide
  logic [2*XLEN-1:0]  acc_q;
  logic [XLEN-1:0]    opb_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dz_q;

  logic               accept, md_start, signed_op;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN:0]      sum, shifted;
  logic [XLEN-1:0]    diff;
  logic               ge;
  logic [2*XLEN-1:0]  mul_next, div_next, prod;
  logic [XLEN-1:0]    res_hi, res_lo;

  assign accept    = bus.start && !bus.flush && (state_q == IDLE);
  assign md_start  = accept && !bus.op[2];
  assign signed_op = !bus.op[0];
  assign a_s       = bus.a;
  assign b_s       = bus.b;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md_start) state_d = ITER;
      ITER:    if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // Iteration step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    mul_next = {sum, acc_q[XLEN-1:1]};
    shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge       = shifted >= {1'b0, opb_q};
    diff     = shifted[XLEN-1:0] - opb_q;
    div_next = {(ge ? diff : shifted[XLEN-1:0]), acc_q[XLEN-2:0], ge};
  end

  // Sign fix; a zero divisor keeps the all-ones quotient unnegated
  always_comb begin
    prod   = neg_if_wide(acc_q, neg_res_q);
    res_hi = is_div_q ? neg_if(acc_q[2*XLEN-1:XLEN], neg_rem_q) : prod[2*XLEN-1:XLEN];
    res_lo = is_div_q ? neg_if(acc_q[XLEN-1:0], neg_res_q && !dz_q) : prod[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == FIX) && !bus.flush;
      if (md_start)
        cnt_q <= '0;
      else if (state_q == ITER)
        cnt_q <= cnt_q + 1'b1;
      if ((state_q == FIX) && !bus.flush) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (accept && bus.op == OP_MTHI) begin
        hi_q <= bus.a;
      end else if (accept && bus.op == OP_MTLO) begin
        lo_q <= bus.a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (md_start) begin
      acc_q     <= {{XLEN{1'b0}}, (signed_op ? mag(a_s) : bus.a)};
      opb_q     <= signed_op ? mag(b_s) : bus.b;
      is_div_q  <= bus.op[1];
      neg_res_q <= signed_op && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
      neg_rem_q <= signed_op && bus.op[1] && bus.a[XLEN-1];
      dz_q      <= (bus.b == '0);
    end else if (state_q == ITER) begin
      acc_q <= is_div_q ? div_next : mul_next;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer with architectural HI/LO registers for the MIPS core.
- Moves MULT/MULTU/DIV/DIVU off the single-cycle ALU, which keeps only ADD..SLTU plus the MUL/MUH/DIV/MOD-style R6 ops.
- Decode issues an op with a start pulse. The pipeline stalls on busy. HI/LO are read combinationally by MFHI/MFLO.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  issue request; sampled only when busy=0.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved.
- a  input  XLEN  rs operand (multiplicand / dividend / MTHI-MTLO data).
- b  input  XLEN  rt operand (multiplier / divisor).
- flush  input  1  abort any in-flight operation.
- busy  output  1  operation in flight; decode must stall MFHI/MFLO/muldiv.
- done  output  1  one-cycle pulse: HI/LO hold the new result.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high, named rst; clock named clk.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards all work and clears HI/LO.
- States: IDLE, ITER, FIX.
- IDLE with start=1, op 0-3:
  - Latch |a| and |b| for signed ops, or raw a and b for unsigned ops.
  - Latch the result-sign and remainder-sign flags.
  - Go to ITER with counter=0.
- IDLE with start=1, op 4/5: hi<=a (MTHI) or lo<=a (MTLO) at that edge. No busy, no done.
- IDLE with start=1, op 6/7: no effect.
- ITER: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract; quotient and remainder registers.
  - Exit after counter==XLEN-1 (32 cycles), then go to FIX.
- FIX, 1 cycle:
  - Apply two's-complement sign correction: product negated if sign(a)^sign(b); quotient likewise; remainder takes sign of a.
  - Write {hi,lo} at the end of FIX. Multiply: hi=upper, lo=lower. Divide: lo=quotient, hi=remainder.
  - Go to IDLE.
- Latency: start accepted at edge E0.
  - busy=1 during cycles 1..33 (32 ITER + FIX).
  - Cycle 34: new hi/lo visible, done=1, busy=0.
  - A new start is accepted in the done cycle (back-to-back issue).
- busy is registered: high exactly when state != IDLE. done is registered, high for exactly one cycle.
- start while busy=1 is ignored. No queuing; decode guarantees the stall.
- Divide by zero (b==0, DIV or DIVU): lo=32'hFFFFFFFF, hi=a. Still takes the full 34 cycles.
- Signed overflow (DIV a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0. Falls out naturally from the magnitude algorithm with sign fix.
- flush=1:
  - Any state goes to IDLE at the next edge.
  - HI/LO keep their pre-operation values; done is not pulsed.
  - A start in the same cycle as flush is ignored.
- flush and rst together: rst wins.
- Operand inputs a and b may change after the start edge without effect.
- Shifts and subtracts are done at XLEN+1 bits to hold the carry/borrow. No overflow flag is produced; HI/LO carry the full result.

Test Plan:
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 34 cycles done=1, hi=32'hFFFFFFFE, lo=32'h00000001; busy high for exactly 33 cycles.
- MULT a=-7 (32'hFFFFFFF9), b=6 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFD6 (-42).
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- Divide by zero and overflow cases:
  - DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5.
  - DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
- MTHI a=32'h12345678, then MTLO a=32'hCAFEF00D -> visible the cycle after each start; busy and done never asserted. Then start MULT, assert flush at cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done.
- Back-to-back and reset:
  - Issue DIVU on the done cycle of a MULTU; start during busy is ignored (hi/lo reflect only the two accepted ops).
  - rst at cycle 20 of a DIV -> busy=0, hi=lo=0 next cycle.
